ins_packer: RTL and testbench
=============================

# ins_packer

Instruction packer and program writer. It takes decoded instruction fields (opcode, registers, funct codes, a full 32-bit signed immediate and an immediate format) and packs them into 32-bit RV32I instruction words. Each packed word is written into instruction memory at consecutive word addresses. It is the inverse of the core's immediate extractor and lets the test harness or boot logic load programs field-by-field. Any packed word fed back through the immediate extractor with the same format must return the original immediate.

## Interface

Parameters:
- `CNT_W`, 16, width of the written-word counter

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  load address counter from `base_addr`; clear count and error
- `base_addr`  in  32  first write address; must be word-aligned
- `in_valid`  in  1  field bundle valid
- `in_ready`  out  1  bundle accepted when `in_valid & in_ready`
- `imm_src`  in  2  immediate format: 00 I, 01 S, 10 B, 11 J
- `imm`  in  32  signed immediate value, byte offset for B/J
- `opcode`  in  7  instruction bits [6:0]
- `rd`  in  5  instruction bits [11:7]; used for I and J
- `rs1`  in  5  instruction bits [19:15]; used for I, S, B
- `rs2`  in  5  instruction bits [24:20]; used for S, B
- `funct3`  in  3  instruction bits [14:12]; used for I, S, B
- `mem_we`  out  1  write request to instruction memory
- `mem_addr`  out  32  write word address
- `mem_wdata`  out  32  packed instruction
- `mem_ready`  in  1  memory accepts the write this cycle
- `count`  out  CNT_W  words written since the last `start`
- `err`  out  1  sticky immediate-range error

## Operation

- FSM has two states.
  - IDLE: no write pending.
  - WRITE: `mem_we`=1; `mem_addr` and `mem_wdata` are held stable.
- `in_ready` = !start & (IDLE | (WRITE & mem_ready)). This is combinational, which allows back-to-back writes.
- On acceptance, the packed word is registered into `mem_wdata`, the current address pointer into `mem_addr`, and the FSM enters WRITE.
- WRITE with `mem_ready`=1:
  - `count`+1 (wraps at 2^CNT_W).
  - Address pointer +4 (wraps mod 2^32).
  - If a new bundle is accepted the same cycle, stay in WRITE with the new word; otherwise go to IDLE.
- Packing by format:
  - I: imm[11:0]→[31:20], rs1, funct3, rd, opcode.
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7], opcode.
  - B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7, opcode.
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd, opcode.
  - Unused fields are ignored.
- `start` takes priority over everything.
  - Next cycle: pointer=`base_addr`, `count`=0, `err`=0, FSM=IDLE.
  - Any pending write is aborted: `mem_we` drops and the write is not counted.

## Timing

- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `count`=0, `err`=0, pointer=0, FSM=IDLE.
- Latency: a bundle accepted at edge N drives `mem_we`=1 with valid address and data from edge N until the edge where `mem_ready`=1 is sampled.
- Throughput: one word per cycle while `mem_ready` is held high.
- Stall: while `mem_ready`=0 in WRITE, all outputs are held stable and `in_ready`=0.
- Reset asserted mid-write: all outputs return immediately to their reset values, asynchronously.

## Configuration

- `INS_PACKER_RANGE_CHECK_EN` defined:
  - An accepted bundle is out of range if its immediate falls outside the format's range:
    - I/S: −2048..2047.
    - B: −4096..4094 and even.
    - J: −1048576..1048574 and even.
  - An out-of-range bundle is consumed but not written: `err` sets the next cycle, and pointer and `count` are unchanged.
  - The FSM goes to, or stays in, IDLE if no valid bundle was accepted.
- Macro not defined:
  - No checking; immediates are silently truncated to the format's bits.
  - `err` is tied to 0.

## Test plan

- Reset, then `start` with `base_addr`=0x100. I-type, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5, with `mem_ready`=1 → `mem_we`, `mem_addr`=0x100, `mem_wdata`=0x00500093; `count`=1.
- S-type, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8 → 0x0020A423 at 0x104. B-type, opcode 0x63, rs1=rs2=0, imm=−4 → 0xFE000EE3 at 0x108.
- J-type, opcode 0x6F, rd=1, imm=0x800 → 0x001000EF. Feeding that word to the immediate extractor with J format returns 0x00000800.
- Four back-to-back bundles with `mem_ready` low for 3 cycles on the second → outputs held during the stall, addresses 0x100/0x104/0x108/0x10C, `count`=4, no drops.
- With the macro defined: B-type imm=3, then I-type imm=2048 → no writes, `err`=1, `count` unchanged. A following valid bundle is written at the unchanged address. `start` clears `err`.
- `start` asserted while WRITE is stalled → `mem_we`=0 next cycle, `count`=0, next write at `base_addr`. `rst_n` pulsed mid-write → all outputs zero immediately.

Source files
------------

// File: rtl/ins_packer.sv
// Packs decoded RV32I fields (I/S/B/J immediate formats) into instruction words and writes them to consecutive memory words.
// Optional immediate range checking is enabled by defining INS_PACKER_RANGE_CHECK_EN.
module ins_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       imm_src,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic [0:0]       dbg_state
);

  // Handshake: a bundle transfers on a rising edge where in_valid & in_ready;
  // a memory write completes on a rising edge where mem_we & mem_ready.
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]  state;
  logic [31:0] ptr;
  logic [31:0] next_ptr;
  logic [31:0] packed_w;
  logic        range_ok;
  logic        done;
  logic        accept;

  assign done      = (state == S_WRITE) && mem_ready;
  assign in_ready  = !start && ((state == S_IDLE) || done);
  assign accept    = in_valid && in_ready;
  // A bundle accepted while the previous write retires goes to the following word.
  assign next_ptr  = done ? (ptr + 32'd4) : ptr;
  assign mem_we    = (state == S_WRITE);
  assign dbg_state = state;

  always_comb begin
    packed_w = 32'd0;
    case (imm_src)
      2'b00:   packed_w = {imm[11:0], rs1, funct3, rd, opcode};
      2'b01:   packed_w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      2'b10:   packed_w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      default: packed_w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    endcase
  end

`ifdef INS_PACKER_RANGE_CHECK_EN
  always_comb begin
    range_ok = 1'b1;
    case (imm_src)
      2'b00, 2'b01: range_ok = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
      2'b10:        range_ok = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
      default:      range_ok = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err <= 1'b0;
    else if (start)                err <= 1'b0;
    else if (accept && !range_ok)  err <= 1'b1;
  end
`else
  assign range_ok = 1'b1;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      count     <= '0;
    end else if (start) begin
      state <= S_IDLE;
      ptr   <= base_addr;
      count <= '0;
    end else begin
      if (done) begin
        count <= count + CNT_ONE;
        ptr   <= ptr + 32'd4;
      end
      if (accept && range_ok) begin
        mem_addr  <= next_ptr;
        mem_wdata <= packed_w;
        state     <= S_WRITE;
      end else if (done) begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ins_packer.sv
// Directed bench for ins_packer: packing of all four formats, stalls, start abort and async reset.
module tb_ins_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  imm_src = 2'b00;
  logic [31:0] imm = 32'd0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [15:0] count;
  logic        err;
  logic [0:0]  dbg_state;

  int total = 0;
  int bad = 0;

  ins_packer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .imm_src(imm_src), .imm(imm),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] src, input logic [31:0] im, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [2:0] f3);
    imm_src = src; imm = im; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3;
  endtask

  // Presents one bundle and returns just after the edge that accepts it.
  task automatic send(input logic [1:0] src, input logic [31:0] im, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3);
    int waited;
    set_fields(src, im, op, d, s1, s2, f3);
    in_valid = 1'b1;
    #1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (waited >= 20) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=%h expected=%h", in_ready, 1'b1);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] base);
    start = 1'b1;
    base_addr = base;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] extract_j(input logic [31:0] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  initial begin
    // Reset values
    #12;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single writes of each format
    do_start(32'h100);
    mem_ready = 1'b1;
    send(2'b00, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    chk("i_we", {31'd0, mem_we}, 32'd1);
    chk("i_addr", mem_addr, 32'h100);
    chk("i_data", mem_wdata, 32'h0050_0093);
    chk("i_count_pending", {16'd0, count}, 32'd0);
    step();
    chk("i_count", {16'd0, count}, 32'd1);
    chk("i_we_drop", {31'd0, mem_we}, 32'd0);

    send(2'b01, 32'd8, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2);
    chk("s_addr", mem_addr, 32'h104);
    chk("s_data", mem_wdata, 32'h0020_A423);
    step();

    send(2'b10, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
    chk("b_addr", mem_addr, 32'h108);
    chk("b_data", mem_wdata, 32'hFE00_0EE3);
    step();

    send(2'b11, 32'h800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
    chk("j_addr", mem_addr, 32'h10C);
    chk("j_data", mem_wdata, 32'h0010_00EF);
    chk("j_roundtrip", extract_j(mem_wdata), 32'h0000_0800);
    step();
    chk("j_count", {16'd0, count}, 32'd4);

    // Back-to-back with a three-cycle stall on the second word
    do_start(32'h100);
    chk("restart_count", {16'd0, count}, 32'd0);
    set_fields(2'b00, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    in_valid = 1'b1;
    step();
    chk("bb0_addr", mem_addr, 32'h100);
    set_fields(2'b00, 32'd2, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0);
    step();
    chk("bb1_addr", mem_addr, 32'h104);
    chk("bb1_data", mem_wdata, 32'h0020_0113);
    chk("bb1_count", {16'd0, count}, 32'd1);
    set_fields(2'b00, 32'd3, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0);
    mem_ready = 1'b0;
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_we", {31'd0, mem_we}, 32'd1);
      chk("stall_addr", mem_addr, 32'h104);
      chk("stall_data", mem_wdata, 32'h0020_0113);
      chk("stall_count", {16'd0, count}, 32'd1);
    end
    mem_ready = 1'b1;
    step();
    chk("bb2_addr", mem_addr, 32'h108);
    chk("bb2_data", mem_wdata, 32'h0030_0193);
    chk("bb2_count", {16'd0, count}, 32'd2);
    set_fields(2'b00, 32'd4, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0);
    step();
    chk("bb3_addr", mem_addr, 32'h10C);
    chk("bb3_count", {16'd0, count}, 32'd3);
    in_valid = 1'b0;
    step();
    chk("bb_count", {16'd0, count}, 32'd4);
    chk("bb_idle", {31'd0, mem_we}, 32'd0);

`ifdef INS_PACKER_RANGE_CHECK_EN
    // Out-of-range immediates are consumed without a write
    do_start(32'h400);
    send(2'b10, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0);
    chk("rng_b_we", {31'd0, mem_we}, 32'd0);
    chk("rng_b_err", {31'd0, err}, 32'd1);
    send(2'b00, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    chk("rng_i_we", {31'd0, mem_we}, 32'd0);
    chk("rng_count", {16'd0, count}, 32'd0);
    send(2'b00, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    chk("rng_ok_addr", mem_addr, 32'h400);
    chk("rng_ok_data", mem_wdata, 32'h0050_0093);
    step();
    chk("rng_ok_count", {16'd0, count}, 32'd1);
    chk("rng_err_sticky", {31'd0, err}, 32'd1);
    do_start(32'h400);
    chk("rng_err_clear", {31'd0, err}, 32'd0);
`else
    // Without checking the immediate is truncated to the format's bits
    do_start(32'h400);
    send(2'b00, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
    chk("trunc_addr", mem_addr, 32'h400);
    chk("trunc_data", mem_wdata, 32'h8000_0093);
    chk("trunc_err", {31'd0, err}, 32'd0);
    step();
    chk("trunc_count", {16'd0, count}, 32'd1);
`endif

    // start aborts a stalled write
    do_start(32'h200);
    mem_ready = 1'b0;
    send(2'b00, 32'd7, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0);
    chk("abort_pending_we", {31'd0, mem_we}, 32'd1);
    chk("abort_state", {31'd0, dbg_state}, 32'd1);
    start = 1'b1;
    base_addr = 32'h300;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    start = 1'b0;
    chk("abort_we", {31'd0, mem_we}, 32'd0);
    chk("abort_count", {16'd0, count}, 32'd0);
    mem_ready = 1'b1;
    send(2'b00, 32'd7, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0);
    chk("abort_next_addr", mem_addr, 32'h300);
    step();
    chk("abort_next_count", {16'd0, count}, 32'd1);

    // Asynchronous reset during a stalled write
    mem_ready = 1'b0;
    send(2'b01, 32'd8, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2);
    chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_data", mem_wdata, 32'd0);
    chk("arst_count", {16'd0, count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
